// File: rtl/adder_tree_pkg.sv
// Shared helpers for the pipelined adder tree.
// Provides a constant-evaluable ceil(log2) and the derived-width helpers
// used by the top level and by any block that has to size ports to match it.
package adder_tree_pkg;

    // ceil(log2(n)); clog2(1) = 0, clog2(16) = 4, clog2(17) = 5.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Number of tree levels (register stages); a single channel still gets one stage.
    function automatic int lvl_of(input int num_ch);
        return (clog2(num_ch) < 1) ? 1 : clog2(num_ch);
    endfunction

    // Full-precision output width: one extra bit per doubling of the channel count.
    function automatic int out_w_of(input int num_ch, input int in_w);
        return in_w + clog2(num_ch);
    endfunction

    // Width needed to hold popcount(ch_mask), i.e. values 0..num_ch.
    function automatic int cnt_w_of(input int num_ch);
        return clog2(num_ch + 1);
    endfunction

endpackage

// File: rtl/adder_tree_pipelined_if.sv
// Stream interface of the adder tree.
//   in_valid/in_ready/in_data/ch_mask : input sample, one NUM_CH*IN_W word plus mask
//   out_valid/out_ready/out_sum/out_count : summed result and enabled-channel count
// Handshake: a word moves across a channel on a rising clock edge where both
// valid and ready are high. A producer holding valid keeps its payload stable
// until that edge; ready may depend combinationally on the consumer's state.
// slave  : the adder tree's view (consumes input side, produces output side)
// master : the surrounding logic's view
interface adder_tree_pipelined_if #(
    parameter int NUM_CH = 16,
    parameter int IN_W   = 23,
    parameter int OUT_W  = 27,
    parameter int CNT_W  = 5
);
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_CH*IN_W-1:0]   in_data;
    logic [NUM_CH-1:0]        ch_mask;
    logic                     out_valid;
    logic                     out_ready;
    logic [OUT_W-1:0]         out_sum;
    logic [CNT_W-1:0]         out_count;

    modport slave (
        input  in_valid, in_data, ch_mask, out_ready,
        output in_ready, out_valid, out_sum, out_count
    );

    modport master (
        output in_valid, in_data, ch_mask, out_ready,
        input  in_ready, out_valid, out_sum, out_count
    );
endinterface

// File: rtl/adder_tree_level.sv
// One level of the adder tree: N_IN operands of W_IN bits reduce to N_IN/2
// registered sums of W_IN+1 bits, so no sum can wrap.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (clears the sums)
//   en_i     : advance enable; when low the registered sums hold
//   in_i     : operand j at bits [j*W_IN +: W_IN]
//   sum_o    : sum j at bits [j*(W_IN+1) +: W_IN+1]
module adder_tree_level #(
    parameter int N_IN   = 2,
    parameter int W_IN   = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en_i,
    input  logic [N_IN*W_IN-1:0]           in_i,
    output logic [(N_IN/2)*(W_IN+1)-1:0]   sum_o
);
    localparam int N_OUT = N_IN / 2;
    localparam int W_OUT = W_IN + 1;

    logic [N_OUT*W_OUT-1:0] sum_d;
    logic [N_OUT*W_OUT-1:0] sum_q;
    logic [W_IN-1:0]        op_a;
    logic [W_IN-1:0]        op_b;
    logic [W_OUT-1:0]       ext_a;
    logic [W_OUT-1:0]       ext_b;

    always_comb begin
        sum_d = '0;
        op_a  = '0;
        op_b  = '0;
        ext_a = '0;
        ext_b = '0;
        for (int j = 0; j < N_OUT; j++) begin
            op_a  = in_i[(2*j)*W_IN   +: W_IN];
            op_b  = in_i[(2*j+1)*W_IN +: W_IN];
            // Extension bit is the sign bit only for two's-complement data.
            ext_a = {(SIGNED && op_a[W_IN-1]), op_a};
            ext_b = {(SIGNED && op_b[W_IN-1]), op_b};
            sum_d[j*W_OUT +: W_OUT] = ext_a + ext_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else if (en_i) begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/adder_tree_pipelined.sv
// Pipelined full-precision adder tree with per-channel mask.
// Sums the enabled channels of a NUM_CH x IN_W sample through LVL register
// stages (one per tree level) and reports popcount(ch_mask) alongside.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high; discards everything in flight
//   bus  : adder_tree_pipelined_if.slave (input sample in, sum/count out)
// The whole pipeline advances as one: it moves whenever the output register
// is empty or being drained, and freezes otherwise, so in_ready = advance.
module adder_tree_pipelined
    import adder_tree_pkg::*;
#(
    parameter int NUM_CH = 16,
    parameter int IN_W   = 23,
    parameter bit SIGNED = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    adder_tree_pipelined_if.slave   bus
);
    localparam int LVL    = lvl_of(NUM_CH);
    localparam int NP     = 1 << LVL;          // channel count padded to a power of 2
    localparam int OUT_W  = out_w_of(NUM_CH, IN_W);
    localparam int CNT_W  = cnt_w_of(NUM_CH);
    localparam int TREE_W = IN_W + LVL;        // exceeds OUT_W only when NUM_CH = 1

    logic                 adv;
    logic [NP*IN_W-1:0]   masked;
    logic [CNT_W-1:0]     pop;
    logic                 vld_d [LVL];
    logic                 vld_q [LVL];
    logic [CNT_W-1:0]     cnt_d [LVL];
    logic [CNT_W-1:0]     cnt_q [LVL];
    logic [TREE_W-1:0]    tree_sum;

    assign adv          = ~vld_q[LVL-1] | bus.out_ready;
    assign bus.in_ready = adv;

    // Disabled channels and padding channels enter the tree as zero.
    always_comb begin
        masked = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.ch_mask[i]) begin
                masked[i*IN_W +: IN_W] = bus.in_data[i*IN_W +: IN_W];
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pop = pop + CNT_W'(bus.ch_mask[i]);
        end
    end

    // Side pipeline: valid and count march in lock-step with the tree stages.
    // A bubble (in_valid = 0) simply shifts a zero valid bit in.
    always_comb begin
        vld_d[0] = bus.in_valid;
        cnt_d[0] = pop;
        for (int k = 1; k < LVL; k++) begin
            vld_d[k] = vld_q[k-1];
            cnt_d[k] = cnt_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LVL; k++) begin
                vld_q[k] <= 1'b0;
                cnt_q[k] <= '0;
            end
        end else if (adv) begin
            vld_q <= vld_d;
            cnt_q <= cnt_d;
        end
    end

    // Level g reduces NP>>g operands of IN_W+g bits; widths grow by one per level.
    for (genvar g = 0; g < LVL; g++) begin : g_lvl
        localparam int NI = NP >> g;
        localparam int WI = IN_W + g;
        logic [(NI/2)*(WI+1)-1:0] q;

        if (g == 0) begin : g_first
            adder_tree_level #(
                .N_IN   (NI),
                .W_IN   (WI),
                .SIGNED (SIGNED)
            ) u_level (
                .clk    (clk),
                .rst    (rst),
                .en_i   (adv),
                .in_i   (masked),
                .sum_o  (q)
            );
        end else begin : g_next
            adder_tree_level #(
                .N_IN   (NI),
                .W_IN   (WI),
                .SIGNED (SIGNED)
            ) u_level (
                .clk    (clk),
                .rst    (rst),
                .en_i   (adv),
                .in_i   (g_lvl[g-1].q),
                .sum_o  (q)
            );
        end
    end

    assign tree_sum      = g_lvl[LVL-1].q;
    // With a single channel the padding partner is zero, so the top bit is redundant.
    assign bus.out_sum   = tree_sum[OUT_W-1:0];
    assign bus.out_count = cnt_q[LVL-1];
    assign bus.out_valid = vld_q[LVL-1];

endmodule

// File: tb/tb_adder_tree_pipelined.sv
// Self-checking bench for adder_tree_pipelined: a 16x23 signed instance with a
// scoreboard, plus 5x8 and 1x8 instances for padding, latency and reset.
module tb_adder_tree_pipelined;
    localparam int O0 = 27;
    localparam int C0 = 5;

    logic clk;
    logic rst;

    int n_cmp;
    int n_err;
    int n_out;

    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    logic [31:0] mon_tmp;
    logic [C0-1:0] mon_cnt;

    adder_tree_pipelined_if #(.NUM_CH(16), .IN_W(23), .OUT_W(27), .CNT_W(5)) b0 ();
    adder_tree_pipelined_if #(.NUM_CH(5),  .IN_W(8),  .OUT_W(11), .CNT_W(3)) b5 ();
    adder_tree_pipelined_if #(.NUM_CH(1),  .IN_W(8),  .OUT_W(8),  .CNT_W(1)) b1 ();

    adder_tree_pipelined #(.NUM_CH(16), .IN_W(23), .SIGNED(1'b1)) u_dut0 (
        .clk (clk), .rst (rst), .bus (b0.slave)
    );
    adder_tree_pipelined #(.NUM_CH(5), .IN_W(8), .SIGNED(1'b1)) u_dut5 (
        .clk (clk), .rst (rst), .bus (b5.slave)
    );
    adder_tree_pipelined #(.NUM_CH(1), .IN_W(8), .SIGNED(1'b1)) u_dut1 (
        .clk (clk), .rst (rst), .bus (b1.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_sum(input logic [367:0] data, input logic [15:0] mask,
                                              input int n, input int w);
        longint acc;
        longint v;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            if (mask[i]) begin
                v = 0;
                for (int b = 0; b < w; b++) v[b] = data[i*w + b];
                if (data[i*w + w - 1]) v = v - (longint'(1) << w);
                acc = acc + v;
            end
        end
        return acc[31:0];
    endfunction

    // ---------------- scoreboard for the 16-channel instance ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (b0.out_valid && b0.out_ready) begin
                n_out++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: got sum=%0d count=%0d, required no output",
                             $signed(b0.out_sum), b0.out_count);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if ({b0.out_count, b0.out_sum} !== mon_exp) begin
                        n_err++;
                        $display("FAIL sb_data: got sum=%0d count=%0d, required sum=%0d count=%0d",
                                 $signed(b0.out_sum), b0.out_count,
                                 $signed(mon_exp[O0-1:0]), mon_exp[31:O0]);
                    end
                end
            end
            if (b0.in_valid && b0.in_ready) begin
                mon_tmp = model_sum(b0.in_data, b0.ch_mask, 16, 23);
                mon_cnt = C0'($countones(b0.ch_mask));
                exp_q.push_back({mon_cnt, mon_tmp[O0-1:0]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send0(input logic [367:0] d, input logic [15:0] m);
        b0.in_data  = d;
        b0.ch_mask  = m;
        b0.in_valid = 1'b1;
        for (int i = 0; i < 50 && !b0.in_ready; i++) tick();
        tick();
        b0.in_valid = 1'b0;
    endtask

    task automatic wait_drain0();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
        end
    endtask

    function automatic logic [367:0] rand_data();
        logic [367:0] d;
        for (int i = 0; i < 16; i++) d[i*23 +: 23] = 23'($urandom);
        return d;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_cmp++;
        if (b0.in_ready !== 1'b1 || b0.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b, required 1 0", b0.in_ready, b0.out_valid);
        end
        n_cmp++;
        if (b0.out_sum !== '0 || b0.out_count !== '0) begin
            n_err++;
            $display("FAIL reset_data: sum=%0d count=%0d, required 0 0", b0.out_sum, b0.out_count);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [367:0] d;
        int n;
        for (int i = 0; i < 16; i++) d[i*23 +: 23] = 23'd1;
        b0.out_ready = 1'b1;
        b0.in_data   = d;
        b0.ch_mask   = 16'hFFFF;
        b0.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        b0.in_valid = 1'b0;
        n = 1;
        @(negedge clk);
        while (!b0.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n !== 4) begin
            n_err++;
            $display("FAIL basic_latency: got %0d edges, required 4", n);
        end
        tick();
        wait_drain0();
    endtask

    task automatic test_extremes();
        logic [367:0] d;
        for (int i = 0; i < 16; i++) d[i*23 +: 23] = 23'h400000;
        send0(d, 16'hFFFF);
        wait_drain0();
        for (int i = 0; i < 16; i++) d[i*23 +: 23] = 23'h3FFFFF;
        send0(d, 16'hFFFF);
        wait_drain0();
    endtask

    task automatic test_mask();
        logic [367:0] d;
        for (int i = 0; i < 16; i++) d[i*23 +: 23] = 23'(i + 1);
        send0(d, 16'h00FF);
        wait_drain0();
        send0(d, 16'h0000);
        wait_drain0();
        send0(rand_data(), 16'hA5C3);
        wait_drain0();
    endtask

    task automatic test_back_to_back();
        int sent;
        int cyc;
        int base;
        logic acc;
        base = n_out;
        sent = 0;
        cyc  = 0;
        b0.in_data = rand_data();
        b0.ch_mask = 16'($urandom);
        while (sent < 20 && cyc < 200) begin
            b0.in_valid  = 1'b1;
            b0.out_ready = !(cyc >= 6 && cyc < 11);
            @(negedge clk);
            if (cyc >= 6 && cyc < 11) begin
                n_cmp++;
                if (b0.in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL stall_in_ready: cycle %0d got %b, required 0", cyc, b0.in_ready);
                end
            end
            acc = b0.in_ready;
            tick();
            if (acc) begin
                sent++;
                b0.in_data = rand_data();
                b0.ch_mask = 16'($urandom);
            end
            cyc++;
        end
        b0.in_valid  = 1'b0;
        b0.out_ready = 1'b1;
        wait_drain0();
        n_cmp++;
        if (n_out - base !== 20) begin
            n_err++;
            $display("FAIL b2b_count: got %0d outputs, required 20", n_out - base);
        end
    endtask

    task automatic test_bubbles();
        logic in_v [12];
        logic out_v [12];
        b0.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            in_v[c]     = (c < 8) && (c % 2 == 0);
            b0.in_valid = in_v[c];
            b0.in_data  = rand_data();
            b0.ch_mask  = 16'($urandom);
            @(negedge clk);
            out_v[c] = b0.out_valid;
            tick();
        end
        b0.in_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            n_cmp++;
            if (out_v[c+4] !== in_v[c]) begin
                n_err++;
                $display("FAIL bubble_pattern: cycle %0d out_valid=%b, required %b", c + 4, out_v[c+4], in_v[c]);
            end
        end
        wait_drain0();
    endtask

    task automatic test_reset_inflight();
        int base;
        b0.out_ready = 1'b0;
        b5.out_ready = 1'b0;
        b1.out_ready = 1'b0;
        b5.in_data   = 40'h0102030405;
        b5.ch_mask   = 5'b11111;
        b1.in_data   = 8'h11;
        b1.ch_mask   = 1'b1;
        for (int s = 0; s < 3; s++) begin
            b0.in_data  = rand_data();
            b0.ch_mask  = 16'hFFFF;
            b0.in_valid = 1'b1;
            b5.in_valid = (s == 0);
            b1.in_valid = (s == 0);
            tick();
        end
        b0.in_valid = 1'b0;
        b5.in_valid = 1'b0;
        b1.in_valid = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({b0.out_valid, b5.out_valid, b1.out_valid} !== 3'b111) begin
            n_err++;
            $display("FAIL inflight_pre: out_valid=%b%b%b, required 111", b0.out_valid, b5.out_valid, b1.out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({b0.out_valid, b5.out_valid, b1.out_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_async: out_valid=%b%b%b, required 000", b0.out_valid, b5.out_valid, b1.out_valid);
        end
        n_cmp++;
        if (b0.out_sum !== '0 || b0.out_count !== '0 || b0.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_clear: sum=%0d count=%0d in_ready=%b, required 0 0 1", b0.out_sum, b0.out_count, b0.in_ready);
        end
        exp_q.delete();
        tick();
        rst = 1'b0;
        b0.out_ready = 1'b1;
        b5.out_ready = 1'b1;
        b1.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        @(negedge clk);
        n_cmp++;
        if ({b0.out_valid, b5.out_valid, b1.out_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_stale: out_valid=%b%b%b, required 000", b0.out_valid, b5.out_valid, b1.out_valid);
        end
        tick();
        base = n_out;
        send0(rand_data(), 16'($urandom));
        wait_drain0();
        n_cmp++;
        if (n_out - base !== 1) begin
            n_err++;
            $display("FAIL rst_next: got %0d outputs, required 1", n_out - base);
        end
    endtask

    task automatic test_ch5(input logic [39:0] d, input logic [4:0] m,
                            input logic [10:0] exp_sum, input logic [2:0] exp_cnt);
        int n;
        b5.out_ready = 1'b1;
        b5.in_data   = d;
        b5.ch_mask   = m;
        b5.in_valid  = 1'b1;
        tick();
        b5.in_valid = 1'b0;
        n = 1;
        @(negedge clk);
        while (!b5.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n !== 3) begin
            n_err++;
            $display("FAIL ch5_latency: got %0d edges, required 3", n);
        end
        n_cmp++;
        if (b5.out_sum !== exp_sum || b5.out_count !== exp_cnt) begin
            n_err++;
            $display("FAIL ch5_data: got sum=%0d count=%0d, required sum=%0d count=%0d",
                     $signed(b5.out_sum), b5.out_count, $signed(exp_sum), exp_cnt);
        end
        tick();
    endtask

    task automatic test_ch1(input logic [7:0] d, input logic m,
                            input logic [7:0] exp_sum, input logic exp_cnt);
        int n;
        b1.out_ready = 1'b1;
        b1.in_data   = d;
        b1.ch_mask   = m;
        b1.in_valid  = 1'b1;
        tick();
        b1.in_valid = 1'b0;
        n = 1;
        @(negedge clk);
        while (!b1.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n !== 1) begin
            n_err++;
            $display("FAIL ch1_latency: got %0d edges, required 1", n);
        end
        n_cmp++;
        if (b1.out_sum !== exp_sum || b1.out_count !== exp_cnt) begin
            n_err++;
            $display("FAIL ch1_data: got sum=%0d count=%0d, required sum=%0d count=%0d",
                     $signed(b1.out_sum), b1.out_count, $signed(exp_sum), exp_cnt);
        end
        tick();
    endtask

    task automatic test_small();
        // ch4..ch0 = 100, -3, 5, 127, -128
        test_ch5({8'd100, 8'hFD, 8'd5, 8'd127, 8'h80}, 5'b11011, 11'd96, 3'd4);
        test_ch5({8'd100, 8'hFD, 8'd5, 8'd127, 8'h80}, 5'b11111, 11'd101, 3'd5);
        test_ch5({8'h80, 8'h80, 8'h80, 8'h80, 8'h80}, 5'b11111, 11'h580, 3'd5);
        test_ch1(8'hB3, 1'b1, 8'hB3, 1'b1);
        test_ch1(8'hB3, 1'b0, 8'h00, 1'b0);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        n_out = 0;
        b0.in_valid = 1'b0; b0.in_data = '0; b0.ch_mask = '0; b0.out_ready = 1'b1;
        b5.in_valid = 1'b0; b5.in_data = '0; b5.ch_mask = '0; b5.out_ready = 1'b1;
        b1.in_valid = 1'b0; b1.in_data = '0; b1.ch_mask = '0; b1.out_ready = 1'b1;

        test_reset();
        test_basic();
        test_extremes();
        test_mask();
        test_back_to_back();
        test_bubbles();
        test_reset_inflight();
        test_small();

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL final_queue: %0d results never produced, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
